uart_rx_deframer: RTL

- Receive front end of the UART receiver; sits directly upstream of the receiver error-check stage.
- Oversamples the serial line and detects the start edge.
- Deserialises one frame: start bit, 8 data bits LSB-first, optional parity bit, stop bit.
- Presents `raw_data`, `start_bit`, `parity_bit` and `stop_bit` with a one-cycle `recieved_flag` strobe. This block only reports sampled framing bits; the error-check stage judges them.

---
 rtl/uart_rx_pkg.sv | 27 ++
 rtl/uart_rx_sampler.sv | 46 ++++
 rtl/uart_rx_deframer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: parity encodings, FSM state
// encoding, frame geometry and small combinational helpers.
package uart_rx_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Only the two defined encodings put a parity bit on the wire.
    function automatic logic has_parity(input logic [1:0] ptype);
        return (ptype == PARITY_ODD) || (ptype == PARITY_EVEN);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning for the UART receiver: 2-flop synchroniser and, when
// UART_RX_MAJORITY_EN is defined, a 3-tick majority voter on the synchronised line.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sample_tick,
    input  logic data_tx,
    output logic line
);

    logic [1:0] sync_r;

    // Synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], data_tx};
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_r;

    // Line values captured on the two preceding ticks; the current value is the third vote.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_r <= 2'b11;
        end else if (sample_tick) begin
            hist_r <= {hist_r[0], sync_r[1]};
        end else begin
            hist_r <= hist_r;
        end
    end

    assign line = maj3(sync_r[1], hist_r[0], hist_r[1]);
`else
    logic tick_unused_s;

    assign tick_unused_s = sample_tick;
    assign line          = sync_r[1];
`endif

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive front end: detects the start edge, deserialises one frame and reports
// the sampled framing bits with a one-cycle strobe. Option macro: UART_RX_MAJORITY_EN.
module uart_rx_deframer
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_tick,
    input  logic       data_tx,
    input  logic [1:0] parity_type,
    output logic [7:0] raw_data,
    output logic       start_bit,
    output logic       parity_bit,
    output logic       stop_bit,
    output logic       recieved_flag,
    output logic       busy
);

    localparam int               CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] START  = ST_START;
    localparam logic [2:0] DATA   = ST_DATA;
    localparam logic [2:0] PARITY = ST_PARITY;
    localparam logic [2:0] STOP   = ST_STOP;

    logic                 line_s;
    logic [2:0]           state_r, state_nxt_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [2:0]           bit_idx_r, bit_idx_nxt_s;
    logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
    logic                 start_r, start_nxt_s;
    logic                 par_r, par_nxt_s;
    logic [1:0]           ptype_r, ptype_nxt_s;
    logic                 done_s;

    uart_rx_sampler u_sampler (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .data_tx     (data_tx),
        .line        (line_s)
    );

    // Frame FSM and datapath; every sample is taken on a sample_tick only.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        start_nxt_s   = start_r;
        par_nxt_s     = par_r;
        ptype_nxt_s   = ptype_r;
        done_s        = 1'b0;
        cnt_inc_s     = cnt_r + CNT_W'(1);
        if (sample_tick) begin
            case (state_r)
                IDLE: begin
                    if (!line_s) begin
                        state_nxt_s   = START;
                        cnt_nxt_s     = CNT_ZERO;
                        bit_idx_nxt_s = 3'd0;
                        ptype_nxt_s   = parity_type;
                    end else begin
                        cnt_nxt_s = CNT_ZERO;
                    end
                end
                // Start is sampled on the tick the counter reaches the half-bit point,
                // which centres every later sample in its bit period.
                START: begin
                    if (cnt_inc_s == MID_CNT) begin
                        start_nxt_s = line_s;
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = DATA;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                DATA: begin
                    if (cnt_r == LAST_CNT) begin
                        cnt_nxt_s     = CNT_ZERO;
                        shift_nxt_s   = {line_s, shift_r[DATA_BITS-1:1]};
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                        if (bit_idx_r == LAST_BIT) begin
                            state_nxt_s = has_parity(ptype_r) ? PARITY : STOP;
                        end else begin
                            state_nxt_s = DATA;
                        end
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                PARITY: begin
                    if (cnt_r == LAST_CNT) begin
                        cnt_nxt_s   = CNT_ZERO;
                        par_nxt_s   = line_s;
                        state_nxt_s = STOP;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                STOP: begin
                    if (cnt_r == LAST_CNT) begin
                        cnt_nxt_s   = CNT_ZERO;
                        done_s      = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end else begin
            done_s = 1'b0;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= {DATA_BITS{1'b0}};
            start_r   <= 1'b0;
            par_r     <= 1'b0;
            ptype_r   <= 2'b00;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
            start_r   <= start_nxt_s;
            par_r     <= par_nxt_s;
            ptype_r   <= ptype_nxt_s;
        end
    end

    // Output fields load on the stop-sample edge and hold until the next frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            raw_data      <= 8'h00;
            start_bit     <= 1'b0;
            parity_bit    <= 1'b0;
            stop_bit      <= 1'b1;
            recieved_flag <= 1'b0;
            busy          <= 1'b0;
        end else begin
            recieved_flag <= done_s;
            busy          <= (state_nxt_s != IDLE);
            if (done_s) begin
                raw_data   <= shift_r;
                start_bit  <= start_r;
                parity_bit <= has_parity(ptype_r) ? par_r : 1'b1;
                stop_bit   <= line_s;
            end else begin
                raw_data   <= raw_data;
                start_bit  <= start_bit;
                parity_bit <= parity_bit;
                stop_bit   <= stop_bit;
            end
        end
    end

endmodule
